// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and the 2-of-3 vote used by the
// 16x oversampling UART receiver.
package uart_pkg;
    localparam int OS_RATE = 16;
    localparam int SMP_W   = $clog2(OS_RATE);

    localparam logic [SMP_W-1:0] SMP_A     = SMP_W'(7);
    localparam logic [SMP_W-1:0] SMP_B     = SMP_W'(8);
    localparam logic [SMP_W-1:0] SMP_C     = SMP_W'(9);
    localparam logic [SMP_W-1:0] TICK_LAST = SMP_W'(15);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one tick every div_i+1 clocks; div_i is only
// picked up when the counter reloads (on a tick or on restart).
module uart_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = div_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with majority-vote bit sampling, optional
// parity, frame/break detection and a held valid/ready output register.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  UART_RX,
    input  logic [DIV_WIDTH-1:0]  DIV_i,
    input  logic                  PARITY_EN_i,
    input  logic                  PARITY_ODD_i,
    output logic [DATA_WIDTH-1:0] DATA_o,
    output logic                  VALID_o,
    input  logic                  READY_i,
    output logic                  FRAME_ERR_o,
    output logic                  PARITY_ERR_o,
    output logic                  BREAK_o,
    output logic                  OVERRUN_o
);
    localparam int BCW = $clog2(DATA_WIDTH + 1);

    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e             state_q, state_d;
    logic [SMP_W-1:0]      smp_cnt_q, smp_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  smp7_q, smp7_d, smp8_q, smp8_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  break_q, break_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic tick, restart, decide, last, maj;
    logic complete, frame_err_n, parity_err_n, break_n;

    uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .restart_i (restart),
        .div_i     (DIV_i),
        .tick_o    (tick)
    );

    assign decide = tick && (smp_cnt_q == SMP_C);
    assign last   = tick && (smp_cnt_q == TICK_LAST);
    // The third vote is the live line value at the tick-9 decision.
    assign maj    = majority3(smp7_q, smp8_q, rx_sync_q);

    assign frame_err_n  = !maj;
    assign parity_err_n = par_en_q && ((^shift_q ^ par_bit_q) != par_odd_q);
    assign break_n      = frame_err_n && (shift_q == '0) && !(par_en_q && par_bit_q);

    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        smp7_d       = smp7_q;
        smp8_d       = smp8_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        restart      = 1'b0;
        complete     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    restart   = 1'b1;
                    state_d   = START;
                    smp_cnt_d = '0;
                    par_en_d  = PARITY_EN_i;
                    par_odd_d = PARITY_ODD_i;
                end
            end
            BRK_WAIT: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (tick) begin
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == SMP_A) smp7_d = rx_sync_q;
                    if (smp_cnt_q == SMP_B) smp8_d = rx_sync_q;
                end
                case (state_q)
                    START: begin
                        if (decide && maj) begin
                            state_d = IDLE;
                        end else if (last) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    DATA: begin
                        if (decide) begin
                            shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                        if (last && bit_cnt_q == BCW'(DATA_WIDTH)) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (decide) par_bit_d = maj;
                        if (last) state_d = STOP;
                    end
                    STOP: begin
                        if (decide) begin
                            complete = 1'b1;
                            state_d  = break_n ? BRK_WAIT : IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // A frame completing while the previous one is still unread is dropped.
    always_comb begin
        data_d       = data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_d      = break_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        if (complete) begin
            if (!valid_q || READY_i) begin
                data_d       = shift_q;
                frame_err_d  = frame_err_n;
                parity_err_d = parity_err_n;
                break_d      = break_n;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && READY_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            smp_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            smp7_q       <= 1'b1;
            smp8_q       <= 1'b1;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            data_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= UART_RX;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            state_q      <= state_d;
            smp_cnt_q    <= smp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp7_q       <= smp7_d;
            smp8_q       <= smp8_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            data_q       <= data_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign DATA_o       = data_q;
    assign VALID_o      = valid_q;
    assign FRAME_ERR_o  = frame_err_q;
    assign PARITY_ERR_o = parity_err_q;
    assign BREAK_o      = break_q;
    assign OVERRUN_o    = overrun_q;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at DIV_i=9 (160 clocks per bit).
module tb_uart_rx_os16;
    import uart_pkg::*;

    localparam int BIT_CLKS = 160;
    // Drive-to-visible-VALID latency: 2 sync + edge detect + 10 clk/tick,
    // stop-bit tick 9 is tick 153 of the frame, +1 edge to load outputs.
    localparam int LAT_NOPAR = 1543;

    logic        clk = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic        UART_RX = 1'b1;
    logic [15:0] DIV_i = 16'd9;
    logic        PARITY_EN_i = 1'b0;
    logic        PARITY_ODD_i = 1'b0;
    logic [7:0]  DATA_o;
    logic        VALID_o;
    logic        READY_i = 1'b1;
    logic        FRAME_ERR_o, PARITY_ERR_o, BREAK_o, OVERRUN_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    int   rise_count = 0, rise_cyc = 0, valid_cycles = 0, hs_count = 0, ovr_count = 0;
    logic [7:0] hs_data = '0;
    logic hs_fe = 1'b0, hs_pe = 1'b0, hs_brk = 1'b0, valid_prev = 1'b0;

    uart_rx_os16 #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .UART_RX       (UART_RX),
        .DIV_i         (DIV_i),
        .PARITY_EN_i   (PARITY_EN_i),
        .PARITY_ODD_i  (PARITY_ODD_i),
        .DATA_o        (DATA_o),
        .VALID_o       (VALID_o),
        .READY_i       (READY_i),
        .FRAME_ERR_o   (FRAME_ERR_o),
        .PARITY_ERR_o  (PARITY_ERR_o),
        .BREAK_o       (BREAK_o),
        .OVERRUN_o     (OVERRUN_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (VALID_o && !valid_prev) begin
            rise_cyc   <= cyc;
            rise_count <= rise_count + 1;
        end
        if (VALID_o) valid_cycles <= valid_cycles + 1;
        if (VALID_o && READY_i) begin
            hs_count <= hs_count + 1;
            hs_data  <= DATA_o;
            hs_fe    <= FRAME_ERR_o;
            hs_pe    <= PARITY_ERR_o;
            hs_brk   <= BREAK_o;
            $display("[%0d] rx data=%02h fe=%0b pe=%0b brk=%0b", cyc, DATA_o, FRAME_ERR_o, PARITY_ERR_o, BREAK_o);
        end
        if (OVERRUN_o) begin
            ovr_count <= ovr_count + 1;
            $display("[%0d] overrun pulse (held data=%02h)", cyc, DATA_o);
        end
        valid_prev <= VALID_o;
    end

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit);
        @(posedge clk); #1;
        start_cyc = cyc;
        UART_RX = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        if (with_par) begin
            UART_RX = par_bit;
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        UART_RX = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (VALID_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID_o); end
        checks++; if (DATA_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", DATA_o); end
        checks++; if (FRAME_ERR_o !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", FRAME_ERR_o); end
        checks++; if (PARITY_ERR_o !== 1'b0) begin errors++; $display("FAIL reset_pe got %b want 0", PARITY_ERR_o); end
        checks++; if (BREAK_o !== 1'b0) begin errors++; $display("FAIL reset_brk got %b want 0", BREAK_o); end
        checks++; if (OVERRUN_o !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", OVERRUN_o); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
        checks++; if (dut.rx_sync_q !== 1'b1) begin errors++; $display("FAIL reset_sync got %b want 1", dut.rx_sync_q); end
        #2 S_AXI_ARESETN = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_basic();
        int r0, v0;
        r0 = rise_count; v0 = valid_cycles;
        READY_i = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rise_count - r0 !== 1) begin errors++; $display("FAIL basic_frames got %0d want 1", rise_count - r0); end
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL basic_valid_len got %0d want 1", valid_cycles - v0); end
        checks++; if (rise_cyc - start_cyc !== LAT_NOPAR) begin errors++; $display("FAIL basic_latency got %0d want %0d", rise_cyc - start_cyc, LAT_NOPAR); end
        checks++; if (hs_data !== 8'h55) begin errors++; $display("FAIL basic_data got %h want 55", hs_data); end
        checks++; if ({hs_fe, hs_pe, hs_brk} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b want 000", {hs_fe, hs_pe, hs_brk}); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_count;
        @(posedge clk); #1;
        UART_RX = 1'b0;
        repeat (40) @(posedge clk);
        #1 UART_RX = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (dut.state_q !== START) begin errors++; $display("FAIL glitch_in_start got %0d want START", dut.state_q); end
        repeat (50) @(posedge clk);
        #1;
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL glitch_idle_by_t9 got %0d want IDLE", dut.state_q); end
        repeat (1700) @(posedge clk);
        #1;
        checks++; if (rise_count - r0 !== 0) begin errors++; $display("FAIL glitch_no_valid got %0d want 0", rise_count - r0); end
    endtask

    task automatic test_parity();
        int r0;
        r0 = rise_count;
        PARITY_EN_i = 1'b1; PARITY_ODD_i = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1);
        checks++; if (hs_data !== 8'hA5) begin errors++; $display("FAIL par1_data got %h want a5", hs_data); end
        checks++; if (hs_pe !== 1'b1) begin errors++; $display("FAIL par1_pe got %b want 1", hs_pe); end
        checks++; if (hs_fe !== 1'b0) begin errors++; $display("FAIL par1_fe got %b want 0", hs_fe); end
        // Flip to odd mid-frame: the frame must still be checked as even.
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin repeat (400) @(posedge clk); #1 PARITY_ODD_i = 1'b1; end
        join
        checks++; if (hs_data !== 8'hA5) begin errors++; $display("FAIL par0_data got %h want a5", hs_data); end
        checks++; if (hs_pe !== 1'b0) begin errors++; $display("FAIL par0_pe got %b want 0", hs_pe); end
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++; if (hs_pe !== 1'b1) begin errors++; $display("FAIL parodd_pe got %b want 1", hs_pe); end
        checks++; if (rise_count - r0 !== 3) begin errors++; $display("FAIL par_frames got %0d want 3", rise_count - r0); end
        PARITY_EN_i = 1'b0; PARITY_ODD_i = 1'b0;
    endtask

    task automatic test_break();
        int r0;
        r0 = rise_count;
        @(posedge clk); #1;
        UART_RX = 1'b0;
        repeat (12 * BIT_CLKS) @(posedge clk);
        #1;
        checks++; if (rise_count - r0 !== 1) begin errors++; $display("FAIL brk_frames got %0d want 1", rise_count - r0); end
        checks++; if (hs_data !== 8'h00) begin errors++; $display("FAIL brk_data got %h want 00", hs_data); end
        checks++; if ({hs_fe, hs_pe, hs_brk} !== 3'b101) begin errors++; $display("FAIL brk_flags got %b want 101", {hs_fe, hs_pe, hs_brk}); end
        checks++; if (dut.state_q !== BRK_WAIT) begin errors++; $display("FAIL brk_wait got %0d want BRK_WAIT", dut.state_q); end
        UART_RX = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL brk_release got %0d want IDLE", dut.state_q); end
        repeat (300) @(posedge clk);
        #1;
        checks++; if (rise_count - r0 !== 1) begin errors++; $display("FAIL brk_single got %0d want 1", rise_count - r0); end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ovr_count;
        READY_i = 1'b0;
        send_frame(8'h31, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        checks++; if (VALID_o !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", VALID_o); end
        checks++; if (DATA_o !== 8'h31) begin errors++; $display("FAIL ovr_data got %h want 31", DATA_o); end
        checks++; if (ovr_count - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_count - o0); end
        READY_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hs_data !== 8'h31) begin errors++; $display("FAIL ovr_drain got %h want 31", hs_data); end
        checks++; if (VALID_o !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b want 0", VALID_o); end

        o0 = ovr_count;
        READY_i = 1'b0;
        send_frame(8'h31, 1'b0, 1'b0);
        fork
            send_frame(8'h32, 1'b0, 1'b0);
            begin
                @(posedge clk); #1;
                repeat (LAT_NOPAR - 1) @(posedge clk);
                #1 READY_i = 1'b1;
                @(posedge clk);
                #1 READY_i = 1'b0;
            end
        join
        checks++; if (VALID_o !== 1'b1) begin errors++; $display("FAIL hs_valid got %b want 1", VALID_o); end
        checks++; if (DATA_o !== 8'h32) begin errors++; $display("FAIL hs_data got %h want 32", DATA_o); end
        checks++; if (ovr_count - o0 !== 0) begin errors++; $display("FAIL hs_no_ovr got %0d want 0", ovr_count - o0); end
        checks++; if (hs_data !== 8'h31) begin errors++; $display("FAIL hs_first got %h want 31", hs_data); end
        READY_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hs_data !== 8'h32) begin errors++; $display("FAIL hs_second got %h want 32", hs_data); end
    endtask

    task automatic test_reset_midframe();
        int r0;
        r0 = rise_count;
        READY_i = 1'b1;
        fork
            send_frame(8'hFF, 1'b0, 1'b0);
            begin
                @(posedge clk); #1;
                repeat (4 * BIT_CLKS + 80) @(posedge clk);
                #3 S_AXI_ARESETN = 1'b0;
                #1;
                checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d want IDLE", dut.state_q); end
                repeat (3) @(posedge clk);
                #3 S_AXI_ARESETN = 1'b1;
            end
        join
        repeat (200) @(posedge clk);
        #1;
        checks++; if (rise_count - r0 !== 0) begin errors++; $display("FAIL rst_mid_no_out got %0d want 0", rise_count - r0); end
        send_frame(8'h7E, 1'b0, 1'b0);
        checks++; if (rise_count - r0 !== 1) begin errors++; $display("FAIL rst_next_frames got %0d want 1", rise_count - r0); end
        checks++; if (hs_data !== 8'h7E) begin errors++; $display("FAIL rst_next_data got %h want 7e", hs_data); end
        checks++; if (hs_fe !== 1'b0) begin errors++; $display("FAIL rst_next_fe got %b want 0", hs_fe); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
